booth_digit_decoder: RTL and testbench



---
 rtl/booth_digit_decoder.sv | 120 ++++++++++++
 tb/tb_booth_digit_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_digit_decoder.sv
// Sequential radix-8 Booth digit decoder: folds one-hot digit selects MSB-first into a signed operand.
// Optional encoding/range checking is enabled by defining BOOTH_DEC_CHECK_EN.
module booth_digit_decoder #(
  parameter int DATA_WIDTH = 16,
  localparam int NUM_PARTIALS = (DATA_WIDTH + 2) / 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PARTIALS-1:0] s,
  input  logic [NUM_PARTIALS-1:0] d,
  input  logic [NUM_PARTIALS-1:0] t,
  input  logic [NUM_PARTIALS-1:0] q,
  input  logic [NUM_PARTIALS-1:0] n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   X,
  output logic                    err
);

  localparam int ACC_W = 3 * NUM_PARTIALS + 1;
  localparam int IDX_W = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic [NUM_PARTIALS-1:0] s_r, d_r, t_r, q_r, n_r;
  logic [ACC_W-1:0]        acc, acc_step;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              mag;
  logic [4:0]              digit;
  logic                    last_digit;

  assign last_digit = (idx == '0);

  // Horner step: acc*8 plus the sign-extended current digit
  always_comb begin
    mag      = 4'(s_r[idx]) + 4'({d_r[idx], 1'b0}) + (t_r[idx] ? 4'd3 : 4'd0)
             + 4'({q_r[idx], 2'b00});
    digit    = n_r[idx] ? 5'(-{1'b0, mag}) : {1'b0, mag};
    acc_step = (acc << 3) + {{(ACC_W-5){digit[4]}}, digit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r <= '0;
      d_r <= '0;
      t_r <= '0;
      q_r <= '0;
      n_r <= '0;
      acc <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_r <= s;
          d_r <= d;
          t_r <= t;
          q_r <= q;
          n_r <= n;
          acc <= '0;
          idx <= IDX_W'(NUM_PARTIALS - 1);
        end
        RUN: begin
          acc <= acc_step;
          if (!last_digit) idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOOTH_DEC_CHECK_EN
  logic                      multi_hot, out_of_range, err_r;
  logic [ACC_W-DATA_WIDTH:0] upper;

  // In range iff every bit above the N-bit sign bit replicates it
  always_comb begin
    multi_hot = 1'b0;
    for (int unsigned i = 0; i < NUM_PARTIALS; i++) begin
      if ((3'(s_r[i]) + 3'(d_r[i]) + 3'(t_r[i]) + 3'(q_r[i])) > 3'd1) multi_hot = 1'b1;
    end
    upper        = acc_step[ACC_W-1:DATA_WIDTH-1];
    out_of_range = !((&upper) || !(|upper));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              err_r <= 1'b0;
    else if (state == RUN && last_digit)   err_r <= multi_hot | out_of_range;
    else if (state == DONE && out_ready)   err_r <= 1'b0;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    X         = acc[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Self-checking bench for booth_digit_decoder (N=16): directed jobs, arithmetic model scoreboard,
// timing, stall and async-reset checks. Expected err follows BOOTH_DEC_CHECK_EN.
module tb_booth_digit_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  s = '0, d = '0, t = '0, q = '0, n = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] X;
  logic        err;

  booth_digit_decoder #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .d(d), .t(t), .q(q), .n(n),
    .out_valid(out_valid), .out_ready(out_ready), .X(X), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] x; logic e; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_lat, last_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Operand value as the plain sum of signed digits times powers of eight
  function automatic exp_t model(input logic [5:0] vs, vd, vt, vq, vn);
    exp_t        r;
    int          total = 0;
    int          mag;
    logic [31:0] bits;
`ifdef BOOTH_DEC_CHECK_EN
    bit          multi = 1'b0;
`endif
    for (int i = 0; i < 6; i++) begin
      mag = int'(vs[i]) + 2 * int'(vd[i]) + 3 * int'(vt[i]) + 4 * int'(vq[i]);
`ifdef BOOTH_DEC_CHECK_EN
      if (int'(vs[i]) + int'(vd[i]) + int'(vt[i]) + int'(vq[i]) > 1) multi = 1'b1;
`endif
      total += (vn[i] ? -mag : mag) * (8 ** i);
    end
    bits = total;
    r.x  = bits[15:0];
`ifdef BOOTH_DEC_CHECK_EN
    r.e  = multi || (total < -32768) || (total > 32767);
`else
    r.e  = 1'b0;
`endif
    return r;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest accepted job
  always @(negedge clk) begin
    #2;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        chk("sb_x", 32'(X), 32'(exp_q[0].x));
        chk("sb_err", 32'(err), 32'(exp_q[0].e));
        chk("sb_in_ready_low", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the first negedge after the accepting edge
  task automatic send(input logic [5:0] vs, vd, vt, vq, vn, output int at);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    s = vs; d = vd; t = vt; q = vq; n = vn;
    in_valid = 1'b1;
    exp_q.push_back(model(vs, vd, vt, vq, vn));
    at = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    s = 6'($urandom); d = 6'($urandom); t = 6'($urandom); q = 6'($urandom); n = 6'($urandom);
  endtask

  // Wait for the result, check the literal value, then wait for in_ready to return
  task automatic finish_job(input logic [15:0] ex, input logic ee, input string name);
    int k = 1;
    int low = 0;
    bit seen = 1'b0;
    last_lat = 0;
    while (k < 40) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        last_lat = k - 1;
        chk({name, "_x"}, 32'(X), 32'(ex));
        chk({name, "_err"}, 32'(err), 32'(ee));
      end
      if (in_ready) break;
      low++;
      @(negedge clk);
      k++;
    end
    if (!seen) chk({name, "_result_timeout"}, 32'(out_valid), 32'd1);
    if (!in_ready) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    last_low = low;
  endtask

  initial begin
    int a1, a2, k;
    exp_t pin;
    logic ce;
`ifdef BOOTH_DEC_CHECK_EN
    ce = 1'b1;
`else
    ce = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(X), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    pin = model(6'b000011, '0, '0, '0, 6'b000010);
    chk("pin_model_m7", 32'(pin.x), 32'h0000FFF9);
    pin = model(6'b100001, '0, '0, '0, 6'b000001);
    chk("pin_model_32767", 32'(pin.x), 32'h00007FFF);

    // 7 = 1*8 - 1
    send(6'b000011, '0, '0, '0, 6'b000001, a1);
    finish_job(16'd7, 1'b0, "x7");
    chk("x7_latency", 32'(last_lat), 32'd6);
    chk("x7_in_ready_low", 32'(last_low), 32'd7);

    // back-to-back 4 then -7
    send(6'b000010, '0, '0, 6'b000001, 6'b000001, a1);
    finish_job(16'd4, 1'b0, "x4");
    send(6'b000011, '0, '0, '0, 6'b000010, a2);
    chk("job_spacing", 32'(a2 - a1), 32'd8);
    finish_job(16'hFFF9, 1'b0, "xm7");

    send(6'b100001, '0, '0, '0, 6'b000001, a1);
    finish_job(16'h7FFF, 1'b0, "max");
    send(6'b100001, '0, '0, '0, 6'b100000, a1);
    finish_job(16'h8001, 1'b0, "negmax");
    send('0, '0, '0, '0, 6'b111111, a1);
    finish_job(16'h0000, 1'b0, "zero_neg");

    // stall with out_ready low
    out_ready = 1'b0;
    send(6'b000011, '0, '0, '0, 6'b000001, a1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_x", 32'(X), 32'd7);
      chk("stall_err", 32'(err), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = (c % 2 == 0);
      s = 6'b111111; q = 6'b111111;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_job(16'd7, 1'b0, "stall_release");

    // async reset in RUN at digit index 2
    send(6'b100001, '0, '0, '0, 6'b000001, a1);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_x", 32'(X), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("arst_no_output", 32'(out_valid), 32'd0);
    end
    // 11 = 1*8 + 3
    send(6'b000010, '0, 6'b000001, '0, '0, a1);
    finish_job(16'd11, 1'b0, "x11");

    // encoding and range errors
    send(6'b000001, 6'b000001, '0, '0, '0, a1);
    finish_job(16'd3, ce, "multihot");
    send('0, '0, '0, 6'b100000, '0, a1);
    finish_job(16'd0, ce, "range");

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
